// File: rtl/soft_error_monitor_pkg.sv
// Shared types for the soft-error monitor: channel FSM encoding and channel indices.
package soft_error_monitor_pkg;

  typedef enum logic [1:0] {
    ST_OK    = 2'd0,
    ST_WARN  = 2'd1,
    ST_ERROR = 2'd2
  } chan_state_e;

  localparam int CH_DATA_CORRUPT  = 0;
  localparam int CH_UNKNOWN_TTC   = 1;
  localparam int CH_DDR3_OVERFLOW = 2;
  localparam int NUM_CH           = 3;

endpackage

// File: rtl/soft_error_channel.sv
// One soft-error channel: saturating event counter, threshold compare and OK/WARN/ERROR FSM.
import soft_error_monitor_pkg::*;

module soft_error_channel #(
  parameter int CNT_W      = 32,
  parameter int WARN_SHIFT = 1
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             event_in,
  input  logic             clear,
  input  logic [CNT_W-1:0] threshold,
  output logic [CNT_W-1:0] count,
  output chan_state_e      state,
  output logic             error_entry
);

  logic [CNT_W-1:0] count_q;
  logic [CNT_W-1:0] warn_level;
  logic             err_hit;
  logic             warn_hit;
  chan_state_e      state_q;
  chan_state_e      state_n;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      count_q <= '0;
    end else if (clear) begin
      count_q <= '0;
    end else if (event_in && (count_q != '1)) begin
      count_q <= count_q + 1'b1;
    end
  end

  // The FSM compares the registered count against the live threshold.
  assign warn_level = threshold >> WARN_SHIFT;
  assign err_hit    = (threshold != '0) && (count_q >= threshold);
  assign warn_hit   = (threshold != '0) && (count_q >= warn_level) && (count_q < threshold);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= ST_OK;
    end else begin
      state_q <= state_n;
    end
  end

  always_comb begin
    state_n = state_q;
    if (clear) begin
      state_n = ST_OK;
    end else begin
      case (state_q)
        ST_OK: begin
          if (err_hit)       state_n = ST_ERROR;
          else if (warn_hit) state_n = ST_WARN;
        end
        ST_WARN: begin
          if (err_hit)        state_n = ST_ERROR;
          else if (!warn_hit) state_n = ST_OK;
        end
        ST_ERROR: state_n = ST_ERROR;
        default:  state_n = ST_OK;
      endcase
    end
  end

  always_comb begin
    count       = count_q;
    state       = state_q;
    error_entry = (state_n == ST_ERROR) && (state_q != ST_ERROR);
  end

endmodule

// File: rtl/soft_error_monitor.sv
// Soft-error monitor: three counting channels with sticky error flags, DDR3 warning and an error-entry pulse.
import soft_error_monitor_pkg::*;

module soft_error_monitor #(
  parameter int CNT_W      = 32,
  parameter int WARN_SHIFT = 1
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             cs_mismatch,
  input  logic             unknown_cmd,
  input  logic             ddr3_overflow,
  input  logic [CNT_W-1:0] thres_data_corrupt,
  input  logic [CNT_W-1:0] thres_unknown_ttc,
  input  logic [CNT_W-1:0] thres_ddr3_overflow,
  input  logic             clear_counts,
  output logic [CNT_W-1:0] cs_mismatch_count,
  output logic [CNT_W-1:0] unknown_cmd_count,
  output logic [CNT_W-1:0] ddr3_overflow_count,
  output logic             error_data_corrupt,
  output logic             error_unknown_ttc,
  output logic             ddr3_overflow_warning,
  output logic             error_ddr3_overflow,
  output logic             error_pulse
);

  logic [NUM_CH-1:0] ev;
  logic [NUM_CH-1:0] entry;
  logic [CNT_W-1:0]  thr [NUM_CH];
  logic [CNT_W-1:0]  cnt [NUM_CH];
  chan_state_e       st  [NUM_CH];
  logic              error_pulse_q;

  assign ev[CH_DATA_CORRUPT]   = cs_mismatch;
  assign ev[CH_UNKNOWN_TTC]    = unknown_cmd;
  assign ev[CH_DDR3_OVERFLOW]  = ddr3_overflow;
  assign thr[CH_DATA_CORRUPT]  = thres_data_corrupt;
  assign thr[CH_UNKNOWN_TTC]   = thres_unknown_ttc;
  assign thr[CH_DDR3_OVERFLOW] = thres_ddr3_overflow;

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    soft_error_channel #(
      .CNT_W      (CNT_W),
      .WARN_SHIFT (WARN_SHIFT)
    ) u_ch (
      .clk         (clk),
      .reset_n     (reset_n),
      .event_in    (ev[i]),
      .clear       (clear_counts),
      .threshold   (thr[i]),
      .count       (cnt[i]),
      .state       (st[i]),
      .error_entry (entry[i])
    );
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      error_pulse_q <= 1'b0;
    end else begin
      error_pulse_q <= |entry;
    end
  end

  assign cs_mismatch_count     = cnt[CH_DATA_CORRUPT];
  assign unknown_cmd_count     = cnt[CH_UNKNOWN_TTC];
  assign ddr3_overflow_count   = cnt[CH_DDR3_OVERFLOW];
  assign error_data_corrupt    = (st[CH_DATA_CORRUPT] == ST_ERROR);
  assign error_unknown_ttc     = (st[CH_UNKNOWN_TTC] == ST_ERROR);
  assign ddr3_overflow_warning = (st[CH_DDR3_OVERFLOW] == ST_WARN) ||
                                 (st[CH_DDR3_OVERFLOW] == ST_ERROR);
  assign error_ddr3_overflow   = (st[CH_DDR3_OVERFLOW] == ST_ERROR);
  assign error_pulse           = error_pulse_q;

endmodule

// File: tb/tb_soft_error_monitor.sv
// Bench for soft_error_monitor: directed test-plan checks plus a cycle model feeding an expected queue.
module tb_soft_error_monitor;

  localparam int W  = 32;
  localparam int SW = 4;
  localparam int VW = 3 * W + 5;

  logic          clk = 1'b0;
  logic          reset_n = 1'b0;
  logic          cs_mismatch = 1'b0, unknown_cmd = 1'b0, ddr3_overflow = 1'b0, clear_counts = 1'b0;
  logic [W-1:0]  thres_data_corrupt = '0, thres_unknown_ttc = '0, thres_ddr3_overflow = '0;
  logic [W-1:0]  cs_mismatch_count, unknown_cmd_count, ddr3_overflow_count;
  logic          error_data_corrupt, error_unknown_ttc, ddr3_overflow_warning;
  logic          error_ddr3_overflow, error_pulse;

  // Narrow instance so counter saturation is reachable in a short run.
  logic          s_cs = 1'b0, s_uk = 1'b0, s_dd = 1'b0, s_clear = 1'b0;
  logic [SW-1:0] s_thr0 = '0, s_thr1 = '0, s_thr2 = '0;
  logic [SW-1:0] s_cnt0, s_cnt1, s_cnt2;
  logic          s_e0, s_e1, s_w2, s_e2, s_p;

  int n_vec = 0;
  int n_err = 0;

  logic [VW-1:0] exp_q[$];
  logic [W-1:0]  m_cnt [3];
  logic [1:0]    m_st  [3];
  logic          m_pulse;

  always #5 clk = ~clk;

  soft_error_monitor #(.CNT_W(W), .WARN_SHIFT(1)) dut (
    .clk(clk), .reset_n(reset_n),
    .cs_mismatch(cs_mismatch), .unknown_cmd(unknown_cmd), .ddr3_overflow(ddr3_overflow),
    .thres_data_corrupt(thres_data_corrupt), .thres_unknown_ttc(thres_unknown_ttc),
    .thres_ddr3_overflow(thres_ddr3_overflow), .clear_counts(clear_counts),
    .cs_mismatch_count(cs_mismatch_count), .unknown_cmd_count(unknown_cmd_count),
    .ddr3_overflow_count(ddr3_overflow_count), .error_data_corrupt(error_data_corrupt),
    .error_unknown_ttc(error_unknown_ttc), .ddr3_overflow_warning(ddr3_overflow_warning),
    .error_ddr3_overflow(error_ddr3_overflow), .error_pulse(error_pulse)
  );

  soft_error_monitor #(.CNT_W(SW), .WARN_SHIFT(1)) dut_s (
    .clk(clk), .reset_n(reset_n),
    .cs_mismatch(s_cs), .unknown_cmd(s_uk), .ddr3_overflow(s_dd),
    .thres_data_corrupt(s_thr0), .thres_unknown_ttc(s_thr1), .thres_ddr3_overflow(s_thr2),
    .clear_counts(s_clear),
    .cs_mismatch_count(s_cnt0), .unknown_cmd_count(s_cnt1), .ddr3_overflow_count(s_cnt2),
    .error_data_corrupt(s_e0), .error_unknown_ttc(s_e1), .ddr3_overflow_warning(s_w2),
    .error_ddr3_overflow(s_e2), .error_pulse(s_p)
  );

  task automatic check_eq(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [VW-1:0] observed();
    return {cs_mismatch_count, unknown_cmd_count, ddr3_overflow_count, error_data_corrupt,
            error_unknown_ttc, ddr3_overflow_warning, error_ddr3_overflow, error_pulse};
  endfunction

  // Reference next state: 0 = OK, 1 = WARN, 2 = ERROR.
  function automatic logic [1:0] model_next(input logic [1:0] st, input logic [W-1:0] c,
                                            input logic [W-1:0] th);
    if (st == 2'd2) return 2'd2;
    if (th == 0) return 2'd0;
    if (c >= th) return 2'd2;
    if (c >= (th >> 1)) return 2'd1;
    return 2'd0;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 3; i++) begin
      m_cnt[i] = '0;
      m_st[i]  = 2'd0;
    end
    m_pulse = 1'b0;
    exp_q.delete();
  endtask

  // Advance one clock: predict outputs from the inputs now driven, then compare after the edge.
  task automatic cycle();
    logic [W-1:0]  th [3];
    logic          ev [3];
    logic [1:0]    ns;
    logic          p;
    logic [VW-1:0] e;
    th[0] = thres_data_corrupt; th[1] = thres_unknown_ttc; th[2] = thres_ddr3_overflow;
    ev[0] = cs_mismatch;        ev[1] = unknown_cmd;       ev[2] = ddr3_overflow;
    p = 1'b0;
    for (int i = 0; i < 3; i++) begin
      if (clear_counts) begin
        ns = 2'd0;
        m_cnt[i] = '0;
      end else begin
        ns = model_next(m_st[i], m_cnt[i], th[i]);
        if (ev[i] && m_cnt[i] != {W{1'b1}}) m_cnt[i] = m_cnt[i] + 1;
      end
      if (ns == 2'd2 && m_st[i] != 2'd2) p = 1'b1;
      m_st[i] = ns;
    end
    m_pulse = p;
    exp_q.push_back({m_cnt[0], m_cnt[1], m_cnt[2], m_st[0] == 2'd2, m_st[1] == 2'd2,
                     m_st[2] != 2'd0, m_st[2] == 2'd2, m_pulse});
    @(posedge clk);
    #1;
    e = exp_q.pop_front();
    check_eq("outputs", observed(), e);
  endtask

  task automatic pulse_cs(input int n);
    for (int i = 0; i < n; i++) begin
      cs_mismatch = 1'b1;
      cycle();
    end
    cs_mismatch = 1'b0;
  endtask

  initial begin
    model_reset();
    #1;
    check_eq("reset_outputs", observed(), '0);
    repeat (2) @(posedge clk);
    #1;
    reset_n = 1'b1;
    cycle();

    // Disabled threshold: counting continues, no error.
    pulse_cs(5);
    cycle();
    check_eq("cs_count_5", cs_mismatch_count, 5);
    check_eq("cs_no_err_thr0", error_data_corrupt, 0);

    // DDR3 threshold 4: warning 2 cycles after pulse 2, error and pulse 2 cycles after pulse 4.
    thres_ddr3_overflow = 4;
    for (int k = 1; k <= 4; k++) begin
      ddr3_overflow = 1'b1;
      cycle();
      ddr3_overflow = 1'b0;
      if (k == 2) check_eq("warn_t1", ddr3_overflow_warning, 0);
      if (k == 4) check_eq("err_t1", {error_ddr3_overflow, error_pulse}, 2'b00);
      cycle();
      if (k == 2) check_eq("warn_t2", ddr3_overflow_warning, 1);
      if (k == 4) check_eq("err_t2", {error_ddr3_overflow, error_pulse}, 2'b11);
    end
    cycle();
    check_eq("err_pulse_single", {error_ddr3_overflow, ddr3_overflow_warning, error_pulse}, 3'b110);

    // Lowering a threshold under the count trips ERROR; raising it again does not clear.
    thres_unknown_ttc = 100;
    unknown_cmd = 1'b1;
    repeat (10) cycle();
    unknown_cmd = 1'b0;
    cycle();
    check_eq("uk_count_10", {unknown_cmd_count, error_unknown_ttc}, {32'd10, 1'b0});
    thres_unknown_ttc = 8;
    cycle();
    check_eq("uk_err_lowered", {error_unknown_ttc, error_pulse}, 2'b11);
    thres_unknown_ttc = 100;
    cycle();
    check_eq("uk_err_sticky", error_unknown_ttc, 1);

    // Saturation on the narrow instance: 14 pulses to max-1, then 3 more.
    s_cs = 1'b1;
    repeat (14) cycle();
    check_eq("sat_pre", s_cnt0, 4'hE);
    repeat (3) cycle();
    s_cs = 1'b0;
    cycle();
    check_eq("sat_hold", s_cnt0, 4'hF);

    // Clear beats a simultaneous event.
    thres_data_corrupt = 5;
    pulse_cs(2);
    cycle();
    check_eq("cs_pre_clear", {cs_mismatch_count, error_data_corrupt}, {32'd7, 1'b1});
    clear_counts = 1'b1;
    cs_mismatch = 1'b1;
    cycle();
    clear_counts = 1'b0;
    cs_mismatch = 1'b0;
    check_eq("clear_wins", observed(), '0);

    // Random traffic against the model.
    for (int n = 0; n < 300; n++) begin
      cs_mismatch   = ($urandom_range(0, 2) == 0);
      unknown_cmd   = ($urandom_range(0, 2) == 0);
      ddr3_overflow = ($urandom_range(0, 1) == 0);
      clear_counts  = ($urandom_range(0, 40) == 0);
      if ($urandom_range(0, 15) == 0) thres_data_corrupt  = $urandom_range(0, 30);
      if ($urandom_range(0, 15) == 0) thres_unknown_ttc   = $urandom_range(0, 30);
      if ($urandom_range(0, 15) == 0) thres_ddr3_overflow = $urandom_range(0, 30);
      cycle();
    end
    clear_counts = 1'b0;

    // Asynchronous reset mid-burst.
    cs_mismatch = 1'b1; unknown_cmd = 1'b1; ddr3_overflow = 1'b1;
    thres_data_corrupt = 2; thres_unknown_ttc = 3; thres_ddr3_overflow = 4;
    repeat (4) cycle();
    #2;
    reset_n = 1'b0;
    #1;
    check_eq("async_reset", observed(), '0);
    model_reset();
    cs_mismatch = 1'b0; unknown_cmd = 1'b0; ddr3_overflow = 1'b0;
    @(posedge clk);
    #1;
    reset_n = 1'b1;
    repeat (3) cycle();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/soft_error_monitor.md
# soft_error_monitor

Counts soft-error events from three sources: checksum mismatch, unknown TTC broadcast command and DDR3 overflow. It compares each count against an IPbus-programmed threshold and raises warning and sticky hard-error flags. It sits directly upstream of the status register block. Its count outputs feed the soft-error count registers, and its error and warning outputs feed the error/warning register and the TTS logic.

## Interface
Parameters:
- CNT_W, 32, counter and threshold width
- WARN_SHIFT, 1, warning level = threshold >> WARN_SHIFT (1 = half threshold)

Ports:
- clk  in  1  user interface clock
- reset_n  in  1  asynchronous active-low reset
- cs_mismatch  in  1  one-cycle pulse per checksum mismatch event
- unknown_cmd  in  1  one-cycle pulse per unknown TTC broadcast command
- ddr3_overflow  in  1  one-cycle pulse per DDR3 overflow event
- thres_data_corrupt  in  CNT_W  checksum-mismatch threshold, 0 = disabled
- thres_unknown_ttc  in  CNT_W  unknown-command threshold, 0 = disabled
- thres_ddr3_overflow  in  CNT_W  DDR3-overflow threshold, 0 = disabled
- clear_counts  in  1  one-cycle pulse from IPbus; zeroes all counters and returns all FSMs to OK
- cs_mismatch_count  out  CNT_W  checksum-mismatch count
- unknown_cmd_count  out  CNT_W  unknown-command count
- ddr3_overflow_count  out  CNT_W  DDR3-overflow count
- error_data_corrupt  out  1  sticky; checksum-mismatch count reached threshold
- error_unknown_ttc  out  1  sticky; unknown-command count reached threshold
- ddr3_overflow_warning  out  1  DDR3-overflow FSM is in WARN or ERROR
- error_ddr3_overflow  out  1  sticky; DDR3-overflow count reached threshold
- error_pulse  out  1  one-cycle pulse when any channel enters ERROR

## Operation
- There are three identical channels: 0 = checksum mismatch, 1 = unknown TTC, 2 = DDR3 overflow.
- Counter behaviour, per channel:
  - Registered; increments by 1 on each cycle its event input is high.
  - Saturates at 2^CNT_W-1, with no wrap.
- Channel FSM states: OK, WARN, ERROR.
  - OK -> WARN: threshold != 0 and count >= (threshold >> WARN_SHIFT) and count < threshold.
  - OK or WARN -> ERROR: threshold != 0 and count >= threshold. OK may jump directly to ERROR.
  - WARN -> OK: warning condition no longer holds (for example, the threshold was raised).
  - ERROR is sticky. It is left only by clear_counts or reset, never by a threshold change.
- Thresholds are sampled every cycle, with no shadow register.
  - Lowering a threshold below the current count moves the channel to ERROR on the next compare.
  - Threshold = 0 holds the FSM in OK (or holds ERROR if already there). Counting continues.
- Error outputs:
  - error_* = (state == ERROR).
  - ddr3_overflow_warning = channel-2 state is WARN or ERROR.
  - Channels 0 and 1 have no warning output; their WARN state is internal.
- error_pulse = OR over channels of (next state == ERROR and current state != ERROR), registered.
- clear_counts:
  - Zeroes all counters and forces all FSMs to OK.
  - Wins over a simultaneous event, which is dropped.
- Reset: all counters 0, all FSMs OK, all outputs 0.

## Timing
- Event pulse high in cycle t: count output shows +1 from cycle t+1.
- FSM compares the registered count. A threshold crossing caused by the event in cycle t gives a state change in cycle t+2. The matching error/warning output and error_pulse are high from cycle t+2; error_pulse lasts one cycle.
- Threshold write in cycle t: state reflects it from cycle t+1.
- clear_counts high in cycle t: counts and flags are 0 from cycle t+1.
- Back-to-back events every cycle count without loss.
- Assertion of reset_n low takes effect immediately, mid-operation, without waiting for a clock edge. Release is synchronous to clk via the design-wide reset synchronizer, not inside this block.

## Structure
- Shared package holds:
  - the channel FSM state encoding (OK = 2'd0, WARN = 2'd1, ERROR = 2'd2);
  - channel index constants.
- One sub-module, soft_error_channel, contains one counter, one compare and one FSM. The top instantiates it three times and ORs the entry pulses into error_pulse.

## Test plan
- Reset, then 5 cs_mismatch pulses with thres_data_corrupt = 0: cs_mismatch_count = 5, error_data_corrupt stays 0.
- thres_ddr3_overflow = 4, then 4 single pulses:
  - ddr3_overflow_warning rises 2 cycles after the 2nd pulse;
  - error_ddr3_overflow and a single error_pulse rise 2 cycles after the 4th pulse.
- Count at 10 with threshold 100, then write threshold 8: error_unknown_ttc = 1 one cycle later. Rewrite threshold to 100: flag stays 1.
- Preload count to 0xFFFFFFFE, then 3 pulses: count holds 0xFFFFFFFF.
- clear_counts and cs_mismatch high in the same cycle with count = 7 and error set: next cycle count = 0 and error = 0.
- Assert reset_n low mid-burst: all outputs 0 before the next clk edge.
